// File: rtl/muldiv_unit.sv
// Iterative RV-XLEN M-extension multiply/divide unit.
// One bit per cycle; start/busy/done handshake with synchronous flush.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic              spec_q;
    logic [XLEN-1:0]   spec_res_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;
    logic [CW-1:0]     cnt_q;

    logic            is_div, sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b, spec_res;
    logic            div_zero, div_ovf, accept, last;

    always_comb begin
        is_div   = op[2];
        sgn_a    = is_div ? !op[0] : (op[1] ^ op[0]);
        sgn_b    = is_div ? !op[0] : (op[1:0] == 2'b01);
        neg_a    = sgn_a & a[XLEN-1];
        neg_b    = sgn_b & b[XLEN-1];
        abs_a    = neg_a ? -a : a;
        abs_b    = neg_b ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !op[0]
                 && (a == {1'b1, {(XLEN-1){1'b0}}})
                 && (b == '1);
        if (div_zero)
            spec_res = op[1] ? a : '1;
        else
            spec_res = op[1] ? '0 : a;
        accept   = (state_q == IDLE) && start && !flush;
        last     = (cnt_q == CW'(XLEN - 1));
    end

    // Multiply: shift-add with the multiplier in the low half of acc.
    // Divide: dividend shifts out of the low half, quotient bits shift in.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic [XLEN+1:0]   trial;
    logic              div_ge;
    logic [XLEN:0]     rem_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        trial    = {rem_q, acc_q[XLEN-1]} - {2'b00, opnd_q};
        div_ge   = !trial[XLEN+1];
        rem_next = div_ge ? trial[XLEN:0]
                          : {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_next = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv, fix_res;

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remv = neg_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        if (spec_q)
            fix_res = spec_res_q;
        else if (!op_q[2] && op_q[1:0] == 2'b00)
            fix_res = prod[XLEN-1:0];
        else if (!op_q[2])
            fix_res = prod[2*XLEN-1:XLEN];
        else if (!op_q[1])
            fix_res = quo;
        else
            fix_res = remv;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)
                      state_d = (div_zero || div_ovf) ? FIX : CALC;
            CALC: if (flush)     state_d = IDLE;
                  else if (last) state_d = FIX;
            FIX:  state_d = flush ? IDLE : DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q       <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result     <= '0;
        end else if (accept) begin
            op_q       <= op;
            neg_a_q    <= neg_a;
            neg_b_q    <= neg_b;
            spec_q     <= div_zero || div_ovf;
            spec_res_q <= spec_res;
            opnd_q     <= is_div ? abs_b : abs_a;
            acc_q      <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
            rem_q      <= '0;
            cnt_q      <= '0;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            if (op_q[2]) begin
                acc_q <= div_next;
                rem_q <= rem_next;
            end else begin
                acc_q <= mul_next;
            end
        end else if (state_q == FIX && !flush) begin
            result <= fix_res;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32).
// Directed spec vectors plus random ops against an arithmetic model.
module tb_muldiv_unit;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_model(
        input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        p  = '0;
        q  = 0;
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                q = sx / sy;
                return q[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                q = sx % sy;
                return q[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int ref_lat(
        input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000
                                && y == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Entered #1 after an edge; leaves #1 after the edge following done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] r,
                          output int lat, output bit busy_ok,
                          output bit idle_ok);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0; busy_ok = 1'b1; idle_ok = 1'b0; r = 'x;
        for (int c = 1; c <= 60; c++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = c;
                r = result;
                break;
            end
            @(posedge CLK); #1;
        end
        if (lat != 0) begin
            @(posedge CLK); #1;
            idle_ok = !busy && !done && (result === r);
            last_res = r;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] exp_r, input int exp_lat);
        logic [31:0] r;
        int lat;
        bit bok, iok;
        run_op(o, x, y, r, lat, bok, iok);
        n_cmp += 3;
        if (r !== exp_r) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, r, exp_r);
        end
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        if (!(bok && iok)) begin
            n_bad++;
            $display("FAIL %s busy window: got busy_ok=%0d idle_ok=%0d want 1/1",
                     name, bok, iok);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({busy, done, result} !== 34'h0) begin
            n_bad++;
            $display("FAIL reset: got busy=%b done=%b result=%h want 0/0/0",
                     busy, done, result);
        end
    endtask

    task automatic test_mul_latency();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_before_start: got busy=%b want 0", busy);
        end
        check_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    endtask

    task automatic test_high_mul();
        check_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        check_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        check_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    endtask

    task automatic test_div();
        check_op("div_-7/2", 3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
        check_op("rem_-7/2", 3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
        check_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        check_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    endtask

    task automatic test_special();
        check_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        check_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
        check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 48; i++) begin
            o = 3'($urandom);
            x = rnd_opnd();
            y = rnd_opnd();
            check_op($sformatf("rand%0d_op%0d_%h_%h", i, o, x, y),
                     o, x, y, ref_model(o, x, y), ref_lat(o, x, y));
        end
    endtask

    task automatic test_flush();
        bit saw_done;
        logic [31:0] prior;
        prior = last_res;
        saw_done = 1'b0;
        op = 3'd4; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            @(posedge CLK); #1;
        end
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        n_cmp += 2;
        if (saw_done || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_state: got busy=%b done=%b early_done=%0d want 0/0/0",
                     busy, done, saw_done);
        end
        if (result !== prior) begin
            n_bad++;
            $display("FAIL flush_result: got %h want %h", result, prior);
        end
        check_op("mul_after_flush", 3'd0, 32'h1234_5678, 32'd3,
                 ref_model(3'd0, 32'h1234_5678, 32'd3), 34);
    endtask

    task automatic test_start_in_done();
        bit got;
        got = 1'b0;
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        op = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n_cmp += 2;
        if (!got) begin
            n_bad++;
            $display("FAIL start_in_done_timeout: got no done want done");
        end
        if (busy !== 1'b0 || result !== 32'd81) begin
            n_bad++;
            $display("FAIL start_in_done: got busy=%b result=%h want 0/%h",
                     busy, result, 32'd81);
        end
        last_res = result;
    endtask

    task automatic test_async_reset();
        op = 3'd1; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, result} !== 34'h0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h want 0/0/0",
                     busy, done, result);
        end
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        check_op("mul_3x4_after_reset", 3'd0, 32'd3, 32'd4, 32'd12, 34);
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        last_res = '0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        RESET = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_mul_latency();
        test_high_mul();
        test_div();
        test_special();
        test_flush();
        test_start_in_done();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
